// File: rtl/store_monitor.sv
// Store-bus self-check for the single-cycle MIPS core: watches data-memory
// stores and reports pass/fail, with a cycle timeout and debug capture.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; store bus ignored
// RUN   | counting cycles, evaluating every store
// PASS  | PASS_DATA seen at PASS_ADDR; sticky until start
// FAIL  | illegal store, wrong data or timeout; sticky until start
module store_monitor #(
  parameter logic [31:0] PASS_ADDR  = 32'd84,
  parameter logic [31:0] PASS_DATA  = 32'd7,
  parameter logic [31:0] ALLOW_ADDR = 32'd80,
  parameter int          TIMEOUT    = 1000,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             memwrite,
  input  logic [31:0]      dataadr,
  input  logic [31:0]      writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [31:0]      last_addr,
  output logic [31:0]      last_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      wr_count    <= '0;
      cycle_count <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (cycle_count != '1)
            cycle_count <= cycle_count + 1'b1;
          if (memwrite) begin
            if (wr_count != '1)
              wr_count <= wr_count + 1'b1;
            last_addr <= dataadr;
            last_data <= writedata;
          end
          // Terminating stores outrank the timeout; ALLOW_ADDR stores do not.
          if (memwrite && dataadr == PASS_ADDR) begin
            done <= 1'b1;
            if (writedata == PASS_DATA) begin
              state <= S_PASS;
              pass  <= 1'b1;
            end else begin
              state     <= S_FAIL;
              fail      <= 1'b1;
              fail_code <= 2'd2;
            end
          end else if (memwrite && dataadr != ALLOW_ADDR) begin
            state     <= S_FAIL;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= 2'd1;
          end else if (cycle_count == TO_LAST) begin
            state     <= S_FAIL;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_code <= 2'd3;
          end
        end
        default: begin
          if (start) begin
            state       <= S_RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 2'd0;
            wr_count    <= '0;
            cycle_count <= '0;
            last_addr   <= '0;
            last_data   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: pass, illegal address, wrong data,
// timeout edge cases, IDLE/reset/restart behaviour.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done, pass, fail;
  logic [1:0]  fail_code;
  logic [15:0] wr_count, cycle_count;
  logic [31:0] last_addr, last_data;

  int total = 0;
  int bad   = 0;

  store_monitor #(.TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .done(done), .pass(pass),
    .fail(fail), .fail_code(fail_code), .wr_count(wr_count),
    .cycle_count(cycle_count), .last_addr(last_addr), .last_data(last_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic p,
                            input logic f, input logic [1:0] c);
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".pass"}, {31'd0, pass}, {31'd0, p});
    chk({tag, ".fail"}, {31'd0, fail}, {31'd0, f});
    chk({tag, ".code"}, {30'd0, fail_code}, {30'd0, c});
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    #10;
    chk_status("rst", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("rst.wr", {16'd0, wr_count}, 32'd0);
    chk("rst.cyc", {16'd0, cycle_count}, 32'd0);
    chk("rst.addr", last_addr, 32'd0);
    chk("rst.data", last_data, 32'd0);
    #12 reset = 1'b1;
    tick();

    // 1: pass run
    pulse_start();
    chk("t1.cyc0", {16'd0, cycle_count}, 32'd0);
    store(32'd80, 32'd10);
    chk_status("t1.a", 1'b0, 1'b0, 1'b0, 2'd0);
    store(32'd80, 32'd3);
    store(32'd84, 32'd7);
    chk_status("t1.b", 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t1.wr", {16'd0, wr_count}, 32'd3);
    chk("t1.cyc", {16'd0, cycle_count}, 32'd3);
    chk("t1.addr", last_addr, 32'd84);
    chk("t1.data", last_data, 32'd7);
    store(32'd88, 32'd5);
    tick();
    chk_status("t1.sticky", 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t1.s.wr", {16'd0, wr_count}, 32'd3);
    chk("t1.s.cyc", {16'd0, cycle_count}, 32'd3);
    chk("t1.s.addr", last_addr, 32'd84);

    // 2: illegal address, start inside RUN ignored
    pulse_start();
    store(32'd80, 32'd1);
    pulse_start();
    chk("t2.cyc", {16'd0, cycle_count}, 32'd2);
    chk("t2.wr1", {16'd0, wr_count}, 32'd1);
    store(32'd88, 32'd5);
    chk_status("t2", 1'b1, 1'b0, 1'b1, 2'd1);
    chk("t2.wr", {16'd0, wr_count}, 32'd2);
    chk("t2.addr", last_addr, 32'd88);
    chk("t2.data", last_data, 32'd5);

    // 3: wrong data at PASS_ADDR
    pulse_start();
    store(32'd84, 32'd6);
    chk_status("t3", 1'b1, 1'b0, 1'b1, 2'd2);
    chk("t3.data", last_data, 32'd6);
    chk("t3.wr", {16'd0, wr_count}, 32'd1);

    // 4a: plain timeout
    pulse_start();
    repeat (19) tick();
    chk_status("t4a.pre", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t4a.cyc19", {16'd0, cycle_count}, 32'd19);
    tick();
    chk_status("t4a", 1'b1, 1'b0, 1'b1, 2'd3);
    chk("t4a.cyc", {16'd0, cycle_count}, 32'd20);
    tick();
    chk("t4a.hold", {16'd0, cycle_count}, 32'd20);

    // 4b: passing store on the timeout edge wins
    pulse_start();
    repeat (19) tick();
    store(32'd84, 32'd7);
    chk_status("t4b", 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t4b.cyc", {16'd0, cycle_count}, 32'd20);

    // 4c: allowed store on the timeout edge still times out
    pulse_start();
    repeat (19) tick();
    store(32'd80, 32'd1);
    chk_status("t4c", 1'b1, 1'b0, 1'b1, 2'd3);
    chk("t4c.wr", {16'd0, wr_count}, 32'd1);
    chk("t4c.addr", last_addr, 32'd80);

    // 5: async reset mid-run, IDLE ignores stores, restart from PASS
    pulse_start();
    store(32'd80, 32'd9);
    tick();
    #2 reset = 1'b0;
    #1;
    chk_status("t5.rst", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t5.rst.wr", {16'd0, wr_count}, 32'd0);
    chk("t5.rst.cyc", {16'd0, cycle_count}, 32'd0);
    chk("t5.rst.addr", last_addr, 32'd0);
    chk("t5.rst.data", last_data, 32'd0);
    tick();
    reset = 1'b1;
    store(32'd88, 32'd5);
    tick();
    chk_status("t5.idle", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t5.idle.wr", {16'd0, wr_count}, 32'd0);
    chk("t5.idle.cyc", {16'd0, cycle_count}, 32'd0);
    chk("t5.idle.addr", last_addr, 32'd0);
    pulse_start();
    store(32'd84, 32'd7);
    chk_status("t5.pass", 1'b1, 1'b1, 1'b0, 2'd0);
    pulse_start();
    chk_status("t5.restart", 1'b0, 1'b0, 1'b0, 2'd0);
    chk("t5.rs.wr", {16'd0, wr_count}, 32'd0);
    chk("t5.rs.cyc", {16'd0, cycle_count}, 32'd0);
    chk("t5.rs.addr", last_addr, 32'd0);
    store(32'd80, 32'd2);
    store(32'd84, 32'd7);
    chk_status("t5.rerun", 1'b1, 1'b1, 1'b0, 2'd0);
    chk("t5.rr.wr", {16'd0, wr_count}, 32'd2);
    chk("t5.rr.cyc", {16'd0, cycle_count}, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
